multi_ch_sync_fifo: RTL and testbench
=====================================

// Module: multi_ch_sync_fifo
// PURPOSE
//  Single-clock, NUM_CH-channel FIFO bank; each channel is an independent DEPTH x DATA_WIDTH queue.
//  Successor to the dual-clock FIFO for same-domain buffering: adds channel count, occupancy count,
//  programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
// PARAMETERS
//  NUM_CH      4  number of independent channels (>=1)
//  DEPTH       8  entries per channel; power of 2, >=2
//  DATA_WIDTH  8  bits per entry
//  AF_MARGIN   1  almost_full asserts when count >= DEPTH-AF_MARGIN (0 < AF_MARGIN < DEPTH)
//  AE_MARGIN   1  almost_empty asserts when count <= AE_MARGIN (0 < AE_MARGIN < DEPTH)
// PORTS
//  clk           in   1                       sole clock, rising edge
//  rstn          in   1                       async active-low reset
//  w_en          in   NUM_CH                  per-channel write request
//  r_en          in   NUM_CH                  per-channel read request
//  data_in       in   NUM_CH*DATA_WIDTH       ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//  data_out      out  NUM_CH*DATA_WIDTH       same packing
//  full          out  NUM_CH                  count == DEPTH
//  empty         out  NUM_CH                  count == 0
//  almost_full   out  NUM_CH                  see AF_MARGIN
//  almost_empty  out  NUM_CH                  see AE_MARGIN
//  count         out  NUM_CH*(PTR_WIDTH+1)    occupancy, PTR_WIDTH=$clog2(DEPTH)
//  overflow      out  NUM_CH                  sticky: write attempted while full
//  underflow     out  NUM_CH                  sticky: read attempted while empty
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. Reset values: data_out 0, full 0, empty 1,
//    almost_full 0, almost_empty 1, count 0, overflow 0, underflow 0; pointers 0. Memory not reset.
//  - Reset mid-operation: all channels empty immediately; stored data discarded; sticky flags cleared.
//  - Channels fully independent; no shared state or arbitration.
//  - Pointers: binary, PTR_WIDTH+1 bits; MSB is wrap bit. full = (addr bits equal, MSBs differ);
//    empty = pointers equal. Wrap from DEPTH-1 to 0 with MSB toggle.
//  - Write accepted iff w_en[i] & !full[i] (full sampled before edge); mem[wptr] <= data, wptr++.
//  - Read accepted iff r_en[i] & !empty[i]; rptr++.
//  - Simultaneous accepted read+write: count unchanged. While full: write rejected even if read
//    accepted same cycle. While empty: read rejected even if write accepted same cycle.
//  - count/full/empty/almost_* are registered, valid the cycle after the causing edge; count
//    changes by at most +/-1 per cycle.
//  - Rejected write: no state change, overflow[i] <= 1. Rejected read: no state change,
//    underflow[i] <= 1. Sticky until rstn.
//  - data_out[i] in standard mode: registered; loaded with mem[rptr] on the edge accepting the read
//    (1-cycle latency); holds last value otherwise.
// CONFIGURATION
//  - Macro MCFIFO_FWFT_EN (first-word fall-through):
//    defined: data_out[i] = mem[rptr] whenever !empty[i] (0 latency); r_en pops the displayed word;
//      word written into an empty channel is visible on data_out the cycle empty deasserts;
//      data_out is don't-care while empty.
//    undefined: standard 1-cycle registered read as above.
// STRUCTURE
//  - Package mcfifo_pkg: function ptr_width(depth) = $clog2(depth); localparam-friendly typedefs
//    for pointer/count width; parameter legality checks via elaboration-time $error in top.
//  - Sub-module sync_fifo_ch: one channel (mem, pointers, flags, count, sticky errors);
//    top instantiates NUM_CH of them in a generate loop and packs/unpacks buses.
// TESTING
//  1. Reset: rstn=0 mid-traffic -> empty=all 1, full=0, count=0, overflow/underflow=0 same cycle.
//  2. Fill ch0 with 0x01..0x08 (DEPTH=8) -> full[0]=1, count=8, almost_full[0]=1 at count 7;
//     other channels stay empty=1.
//  3. Write 0x09 to full ch0 -> overflow[0]=1, count stays 8; drain -> reads 0x01..0x08 in order,
//     0x09 never appears; 1-cycle latency (0 with MCFIFO_FWFT_EN).
//  4. Read empty ch1 -> underflow[1]=1, data_out[1] unchanged, count stays 0.
//  5. Simultaneous w_en/r_en on ch2 at count 4 for 20 cycles -> count stays 4, pointers wrap,
//     data order preserved; at full: read accepted, write rejected, overflow set.
//  6. All NUM_CH channels written/read with distinct random streams -> per-channel scoreboard
//     match, no cross-channel corruption.

Source files
------------

// File: rtl/mcfifo_pkg.sv
// ----------------------------------------------------------------------------
// mcfifo_pkg
//  Shared definitions for the multi-channel synchronous FIFO bank.
//  - ptr_width()    : address width for a given channel depth
//  - count_width()  : occupancy/pointer width (address bits plus wrap bit)
//  - is_pow2()      : helper used by the top-level parameter legality checks
//  - ch_status_t    : per-channel flag bundle returned by sync_fifo_ch
//  - CH_STATUS_RESET: flag values every channel returns to on reset
// ----------------------------------------------------------------------------
package mcfifo_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } ch_status_t;

    localparam ch_status_t CH_STATUS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/sync_fifo_ch.sv
// ----------------------------------------------------------------------------
// sync_fifo_ch
//  One channel of the FIFO bank: DEPTH x DATA_WIDTH storage, binary pointers
//  with a wrap bit, registered occupancy count and flags, sticky error flags.
//
//  Optional build macro MCFIFO_FWFT_EN selects first-word fall-through output
//  (data_out shows the head entry combinationally). Without it data_out is a
//  register loaded on each accepted read.
//
//  Ports
//   clk       in   rising-edge clock
//   rstn      in   asynchronous active-low reset
//   w_en      in   write request
//   r_en      in   read request
//   data_in   in   write data
//   data_out  out  read data
//   count     out  occupancy, 0..DEPTH
//   status    out  full/empty/almost flags and sticky overflow/underflow
// ----------------------------------------------------------------------------
module sync_fifo_ch
    import mcfifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      w_en,
    input  logic                      r_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [ptr_width(DEPTH):0] count,
    output ch_status_t                status
);

    localparam int PTR_WIDTH = ptr_width(DEPTH);

    localparam logic [PTR_WIDTH:0] PTR_ONE  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH:0] AF_LEVEL = (PTR_WIDTH + 1)'(DEPTH - AF_MARGIN);
    localparam logic [PTR_WIDTH:0] AE_LEVEL = (PTR_WIDTH + 1)'(AE_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH:0]   wptr;
    logic [PTR_WIDTH:0]   rptr;
    logic [PTR_WIDTH:0]   wptr_next;
    logic [PTR_WIDTH:0]   rptr_next;
    logic [PTR_WIDTH:0]   count_q;
    logic [PTR_WIDTH:0]   count_next;
    ch_status_t           status_q;
    ch_status_t           status_next;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [PTR_WIDTH-1:0] waddr;
    logic [PTR_WIDTH-1:0] raddr;

    assign waddr = wptr[PTR_WIDTH-1:0];
    assign raddr = rptr[PTR_WIDTH-1:0];

    // Acceptance uses the registered flags, so a full channel rejects a write
    // even when a read frees a slot on the same edge (and likewise for empty).
    // All flags are derived from the post-edge pointers so that they line up
    // with count on the cycle after the causing edge.
    always_comb begin
        wr_acc      = w_en & ~status_q.full;
        rd_acc      = r_en & ~status_q.empty;
        wptr_next   = wr_acc ? (wptr + PTR_ONE) : wptr;
        rptr_next   = rd_acc ? (rptr + PTR_ONE) : rptr;
        count_next  = wptr_next - rptr_next;
        status_next = status_q;

        status_next.full         = (wptr_next[PTR_WIDTH-1:0] == rptr_next[PTR_WIDTH-1:0]) &&
                                   (wptr_next[PTR_WIDTH]     != rptr_next[PTR_WIDTH]);
        status_next.empty        = (wptr_next == rptr_next);
        status_next.almost_full  = (count_next >= AF_LEVEL);
        status_next.almost_empty = (count_next <= AE_LEVEL);
        status_next.overflow     = status_q.overflow  | (w_en & status_q.full);
        status_next.underflow    = status_q.underflow | (r_en & status_q.empty);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            status_q <= CH_STATUS_RESET;
        end else begin
            wptr     <= wptr_next;
            rptr     <= rptr_next;
            count_q  <= count_next;
            status_q <= status_next;
        end
    end

    // Storage is deliberately left out of reset; emptiness is tracked by the
    // pointers alone.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[waddr] <= data_in;
        end
    end

`ifdef MCFIFO_FWFT_EN
    // Head entry is always presented; the value is meaningless while empty.
    assign data_out = mem[raddr];
`else
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else if (rd_acc) begin
            data_q <= mem[raddr];
        end
    end

    assign data_out = data_q;
`endif

    assign count  = count_q;
    assign status = status_q;

endmodule

// File: rtl/multi_ch_sync_fifo.sv
// ----------------------------------------------------------------------------
// multi_ch_sync_fifo
//  Single-clock bank of NUM_CH fully independent FIFO channels, each DEPTH
//  entries of DATA_WIDTH bits, with occupancy count, programmable almost-full
//  / almost-empty flags and sticky overflow/underflow flags.
//
//  Optional build macro MCFIFO_FWFT_EN: first-word fall-through read data
//  (head entry visible with zero latency). Default is a 1-cycle registered
//  read.
//
//  Ports (channel i occupies slice i of each bus)
//   clk           in   rising-edge clock
//   rstn          in   asynchronous active-low reset
//   w_en          in   [NUM_CH]             write request per channel
//   r_en          in   [NUM_CH]             read request per channel
//   data_in       in   [NUM_CH*DATA_WIDTH]  write data, ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_out      out  [NUM_CH*DATA_WIDTH]  read data, same packing
//   full          out  [NUM_CH]             count == DEPTH
//   empty         out  [NUM_CH]             count == 0
//   almost_full   out  [NUM_CH]             count >= DEPTH-AF_MARGIN
//   almost_empty  out  [NUM_CH]             count <= AE_MARGIN
//   count         out  [NUM_CH*CNT_WIDTH]   occupancy per channel
//   overflow      out  [NUM_CH]             sticky: write attempted while full
//   underflow     out  [NUM_CH]             sticky: read attempted while empty
// ----------------------------------------------------------------------------
module multi_ch_sync_fifo
    import mcfifo_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DEPTH      = 8,
    parameter  int DATA_WIDTH = 8,
    parameter  int AF_MARGIN  = 1,
    parameter  int AE_MARGIN  = 1,
    localparam int CNT_WIDTH  = count_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            w_en,
    input  logic [NUM_CH-1:0]            r_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH-1:0]            empty,
    output logic [NUM_CH-1:0]            almost_full,
    output logic [NUM_CH-1:0]            almost_empty,
    output logic [NUM_CH*CNT_WIDTH-1:0]  count,
    output logic [NUM_CH-1:0]            overflow,
    output logic [NUM_CH-1:0]            underflow
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("multi_ch_sync_fifo: NUM_CH must be at least 1");
    end

    if ((DEPTH < 2) || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("multi_ch_sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    if ((AF_MARGIN <= 0) || (AF_MARGIN >= DEPTH)) begin : g_bad_af_margin
        $error("multi_ch_sync_fifo: AF_MARGIN must satisfy 0 < AF_MARGIN < DEPTH");
    end

    if ((AE_MARGIN <= 0) || (AE_MARGIN >= DEPTH)) begin : g_bad_ae_margin
        $error("multi_ch_sync_fifo: AE_MARGIN must satisfy 0 < AE_MARGIN < DEPTH");
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ch_status_t ch_status;

        sync_fifo_ch #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .AF_MARGIN  (AF_MARGIN),
            .AE_MARGIN  (AE_MARGIN)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .w_en     (w_en[ch]),
            .r_en     (r_en[ch]),
            .data_in  (data_in[ch*DATA_WIDTH +: DATA_WIDTH]),
            .data_out (data_out[ch*DATA_WIDTH +: DATA_WIDTH]),
            .count    (count[ch*CNT_WIDTH +: CNT_WIDTH]),
            .status   (ch_status)
        );

        assign full[ch]         = ch_status.full;
        assign empty[ch]        = ch_status.empty;
        assign almost_full[ch]  = ch_status.almost_full;
        assign almost_empty[ch] = ch_status.almost_empty;
        assign overflow[ch]     = ch_status.overflow;
        assign underflow[ch]    = ch_status.underflow;
    end

endmodule

// File: tb/tb_multi_ch_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_multi_ch_sync_fifo
//  Directed self-checking bench for multi_ch_sync_fifo (NUM_CH=4, DEPTH=8,
//  DATA_WIDTH=8, AF_MARGIN=1, AE_MARGIN=1). Inputs change on the falling edge;
//  outputs are checked on the falling edge after the rising edge they follow.
//  Honours MCFIFO_FWFT_EN for read-data timing.
// ----------------------------------------------------------------------------
module tb_multi_ch_sync_fifo;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int DW     = 8;
    localparam int CW     = 4;

    logic                 clk;
    logic                 rstn;
    logic [NUM_CH-1:0]    w_en;
    logic [NUM_CH-1:0]    r_en;
    logic [NUM_CH*DW-1:0] data_in;
    logic [NUM_CH*DW-1:0] data_out;
    logic [NUM_CH-1:0]    full;
    logic [NUM_CH-1:0]    empty;
    logic [NUM_CH-1:0]    almost_full;
    logic [NUM_CH-1:0]    almost_empty;
    logic [NUM_CH*CW-1:0] count;
    logic [NUM_CH-1:0]    overflow;
    logic [NUM_CH-1:0]    underflow;

    int checks = 0;
    int errors = 0;

    multi_ch_sync_fifo #(
        .NUM_CH     (NUM_CH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .AF_MARGIN  (1),
        .AE_MARGIN  (1)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dout_of(input int ch);
        return data_out[ch*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] count_of(input int ch);
        return count[ch*CW +: CW];
    endfunction

    task automatic do_reset();
        w_en    = '0;
        r_en    = '0;
        data_in = '0;
        rstn    = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty !== 4'hF || full !== 4'h0 || almost_empty !== 4'hF || almost_full !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got e=%b f=%b ae=%b af=%b expected e=1111 f=0000 ae=1111 af=0000",
                     empty, full, almost_empty, almost_full);
        end
        checks++;
        if (count !== 16'h0 || overflow !== 4'h0 || underflow !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_count_err: got count=%h ov=%b uf=%b expected 0000/0000/0000",
                     count, overflow, underflow);
        end
`ifndef MCFIFO_FWFT_EN
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data_out: got %h expected 00000000", data_out);
        end
`endif

        // Traffic on ch0/ch1 and an underflowing read on ch3, then reset mid-cycle.
        w_en = 4'b0011;
        r_en = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            data_in = {8'h00, 8'h00, 8'(8'h50 + i), 8'(8'h40 + i)};
            @(negedge clk);
        end
        checks++;
        if (count_of(0) !== 4'd3 || count_of(1) !== 4'd3 || underflow !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL pre_reset_traffic: got c0=%0d c1=%0d uf=%b expected 3/3/1000",
                     count_of(0), count_of(1), underflow);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (empty !== 4'hF || full !== 4'h0 || count !== 16'h0 ||
            overflow !== 4'h0 || underflow !== 4'h0 || almost_empty !== 4'hF) begin
            errors++;
            $display("[TB] FAIL async_reset: got e=%b f=%b count=%h ov=%b uf=%b ae=%b expected 1111/0000/0000/0000/0000/1111",
                     empty, full, count, overflow, underflow, almost_empty);
        end
        w_en = '0;
        r_en = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (empty !== 4'hF || count !== 16'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got e=%b count=%h expected 1111/0000", empty, count);
        end
    endtask

    task automatic test_fill();
        w_en = 4'b0001;
        for (int i = 1; i <= DEPTH; i++) begin
            data_in = {24'h0, 8'(i)};
            @(negedge clk);
            checks++;
            if (count_of(0) !== 4'(i)) begin
                errors++;
                $display("[TB] FAIL fill_count: got %0d expected %0d", count_of(0), i);
            end
            checks++;
            if (almost_full[0] !== (i >= 7) || almost_empty[0] !== (i <= 1)) begin
                errors++;
                $display("[TB] FAIL fill_almost at count %0d: got af=%b ae=%b expected af=%b ae=%b",
                         i, almost_full[0], almost_empty[0], (i >= 7), (i <= 1));
            end
        end
        w_en = '0;
        checks++;
        if (full !== 4'b0001 || empty !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL fill_flags: got f=%b e=%b expected 0001/1110", full, empty);
        end
    endtask

    task automatic test_overflow_drain();
        w_en    = 4'b0001;
        data_in = {24'h0, 8'h09};
        @(negedge clk);
        w_en = '0;
        checks++;
        if (overflow !== 4'b0001 || count_of(0) !== 4'd8 || full[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_set: got ov=%b count=%0d full=%b expected 0001/8/1",
                     overflow, count_of(0), full[0]);
        end
        for (int i = 1; i <= DEPTH; i++) begin
`ifdef MCFIFO_FWFT_EN
            checks++;
            if (dout_of(0) !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL drain_data: got %h expected %h", dout_of(0), 8'(i));
            end
`endif
            r_en = 4'b0001;
            @(negedge clk);
`ifndef MCFIFO_FWFT_EN
            checks++;
            if (dout_of(0) !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL drain_data: got %h expected %h", dout_of(0), 8'(i));
            end
`endif
            checks++;
            if (count_of(0) !== 4'(DEPTH - i)) begin
                errors++;
                $display("[TB] FAIL drain_count: got %0d expected %0d", count_of(0), DEPTH - i);
            end
        end
        r_en = '0;
        checks++;
        if (empty[0] !== 1'b1 || underflow[0] !== 1'b0 || overflow[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_end_flags: got e=%b uf=%b ov=%b expected 1/0/1",
                     empty[0], underflow[0], overflow[0]);
        end
    endtask

    task automatic test_underflow();
        r_en = 4'b0010;
        @(negedge clk);
        r_en = '0;
        checks++;
        if (underflow !== 4'b0010 || count_of(1) !== 4'd0 || empty[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_set: got uf=%b count=%0d e=%b expected 0010/0/1",
                     underflow, count_of(1), empty[1]);
        end
`ifndef MCFIFO_FWFT_EN
        checks++;
        if (dout_of(1) !== 8'h00) begin
            errors++;
            $display("[TB] FAIL underflow_data_hold: got %h expected 00", dout_of(1));
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_rd;
        w_en = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            data_in = {8'h00, 8'(8'h20 + i), 16'h0};
            q.push_back(8'(8'h20 + i));
            @(negedge clk);
        end
        checks++;
        if (count_of(2) !== 4'd4) begin
            errors++;
            $display("[TB] FAIL b2b_prefill: got %0d expected 4", count_of(2));
        end
        for (int k = 0; k < 20; k++) begin
            exp_rd = q.pop_front();
`ifdef MCFIFO_FWFT_EN
            checks++;
            if (dout_of(2) !== exp_rd) begin
                errors++;
                $display("[TB] FAIL b2b_data: got %h expected %h", dout_of(2), exp_rd);
            end
`endif
            w_en    = 4'b0100;
            r_en    = 4'b0100;
            data_in = {8'h00, 8'(8'h24 + k), 16'h0};
            q.push_back(8'(8'h24 + k));
            @(negedge clk);
`ifndef MCFIFO_FWFT_EN
            checks++;
            if (dout_of(2) !== exp_rd) begin
                errors++;
                $display("[TB] FAIL b2b_data: got %h expected %h", dout_of(2), exp_rd);
            end
`endif
            checks++;
            if (count_of(2) !== 4'd4) begin
                errors++;
                $display("[TB] FAIL b2b_count: got %0d expected 4", count_of(2));
            end
        end
        r_en = '0;
        for (int i = 0; i < 4; i++) begin
            data_in = {8'h00, 8'(8'h60 + i), 16'h0};
            q.push_back(8'(8'h60 + i));
            @(negedge clk);
        end
        checks++;
        if (full[2] !== 1'b1 || count_of(2) !== 4'd8 || overflow[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_full: got f=%b count=%0d ov=%b expected 1/8/0",
                     full[2], count_of(2), overflow[2]);
        end
        // Full: read must be taken, write of 0xEE must be dropped.
        exp_rd  = q.pop_front();
        w_en    = 4'b0100;
        r_en    = 4'b0100;
        data_in = {8'h00, 8'hEE, 16'h0};
        @(negedge clk);
        w_en = '0;
        checks++;
        if (count_of(2) !== 4'd7 || overflow[2] !== 1'b1 || full[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_full_rw: got count=%0d ov=%b f=%b expected 7/1/0",
                     count_of(2), overflow[2], full[2]);
        end
`ifndef MCFIFO_FWFT_EN
        checks++;
        if (dout_of(2) !== exp_rd) begin
            errors++;
            $display("[TB] FAIL b2b_full_rw_data: got %h expected %h", dout_of(2), exp_rd);
        end
`endif
        for (int i = 0; i < 7; i++) begin
            exp_rd = q.pop_front();
`ifdef MCFIFO_FWFT_EN
            checks++;
            if (dout_of(2) !== exp_rd) begin
                errors++;
                $display("[TB] FAIL b2b_drain: got %h expected %h", dout_of(2), exp_rd);
            end
`endif
            @(negedge clk);
`ifndef MCFIFO_FWFT_EN
            checks++;
            if (dout_of(2) !== exp_rd) begin
                errors++;
                $display("[TB] FAIL b2b_drain: got %h expected %h", dout_of(2), exp_rd);
            end
`endif
        end
        r_en = '0;
        checks++;
        if (empty[2] !== 1'b1 || count_of(2) !== 4'd0) begin
            errors++;
            $display("[TB] FAIL b2b_drain_empty: got e=%b count=%0d expected 1/0", empty[2], count_of(2));
        end
    endtask

    task automatic test_multi_channel();
        logic [DW-1:0] mdata [NUM_CH][DEPTH];
        int            mhead [NUM_CH];
        int            mcnt  [NUM_CH];
        logic [NUM_CH-1:0] mov;
        logic [NUM_CH-1:0] muf;
        logic [DW-1:0] exp_rd [NUM_CH];
        bit            racc   [NUM_CH];
        bit            wr, rd;
        logic [DW-1:0] wd;

        do_reset();
        mov = '0;
        muf = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            mhead[ch] = 0;
            mcnt[ch]  = 0;
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef MCFIFO_FWFT_EN
                if (mcnt[ch] > 0) begin
                    checks++;
                    if (dout_of(ch) !== mdata[ch][mhead[ch]]) begin
                        errors++;
                        $display("[TB] FAIL multi_data ch%0d cyc%0d: got %h expected %h",
                                 ch, cyc, dout_of(ch), mdata[ch][mhead[ch]]);
                    end
                end
`endif
                wr = ($urandom_range(0, 99) < 55);
                rd = ($urandom_range(0, 99) < 50);
                wd = 8'($urandom_range(0, 255));
                w_en[ch] = wr;
                r_en[ch] = rd;
                data_in[ch*DW +: DW] = wd;
                if (wr && mcnt[ch] == DEPTH) mov[ch] = 1'b1;
                if (rd && mcnt[ch] == 0)     muf[ch] = 1'b1;
                racc[ch] = rd && (mcnt[ch] != 0);
                if (racc[ch]) begin
                    exp_rd[ch] = mdata[ch][mhead[ch]];
                end
                if (wr && mcnt[ch] != DEPTH) begin
                    mdata[ch][(mhead[ch] + mcnt[ch]) % DEPTH] = wd;
                end
                if (racc[ch]) begin
                    mhead[ch] = (mhead[ch] + 1) % DEPTH;
                end
                mcnt[ch] = mcnt[ch] + ((wr && mcnt[ch] != DEPTH) ? 1 : 0) - (racc[ch] ? 1 : 0);
            end
            @(negedge clk);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                checks++;
                if (count_of(ch) !== 4'(mcnt[ch])) begin
                    errors++;
                    $display("[TB] FAIL multi_count ch%0d cyc%0d: got %0d expected %0d",
                             ch, cyc, count_of(ch), mcnt[ch]);
                end
`ifndef MCFIFO_FWFT_EN
                if (racc[ch]) begin
                    checks++;
                    if (dout_of(ch) !== exp_rd[ch]) begin
                        errors++;
                        $display("[TB] FAIL multi_data ch%0d cyc%0d: got %h expected %h",
                                 ch, cyc, dout_of(ch), exp_rd[ch]);
                    end
                end
`endif
            end
        end
        w_en = '0;
        r_en = '0;
        checks++;
        if (overflow !== mov || underflow !== muf) begin
            errors++;
            $display("[TB] FAIL multi_sticky: got ov=%b uf=%b expected ov=%b uf=%b",
                     overflow, underflow, mov, muf);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        w_en    = '0;
        r_en    = '0;
        data_in = '0;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_back_to_back();
        test_multi_channel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
